// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer and its program buffer.
package seq_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FIELD_W = 4;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned SRC1_MSB   = 11;
  localparam int unsigned SRC1_LSB   = 8;
  localparam int unsigned SRC2_MSB   = 7;
  localparam int unsigned SRC2_LSB   = 4;
  localparam int unsigned DST_MSB    = 3;
  localparam int unsigned DST_LSB    = 0;

  localparam logic [FIELD_W-1:0] OP_LDI = 4'h0;
  localparam logic [FIELD_W-1:0] OP_LD  = 4'h1;
  localparam logic [FIELD_W-1:0] OP_ST  = 4'h2;
  localparam logic [FIELD_W-1:0] OP_ADD = 4'h3;
  localparam logic [FIELD_W-1:0] OP_SUB = 4'h4;
  localparam logic [FIELD_W-1:0] OP_AND = 4'h5;
  localparam logic [FIELD_W-1:0] OP_OR  = 4'h6;
  localparam logic [FIELD_W-1:0] OP_XOR = 4'h7;
  localparam logic [FIELD_W-1:0] OP_NOT = 4'h8;
  localparam logic [FIELD_W-1:0] OP_SHL = 4'h9;
  localparam logic [FIELD_W-1:0] OP_SHR = 4'hA;
  localparam logic [FIELD_W-1:0] OP_INC = 4'hB;
  localparam logic [FIELD_W-1:0] OP_DEC = 4'hC;
  localparam logic [FIELD_W-1:0] OP_CMP = 4'hD;
  localparam logic [FIELD_W-1:0] OP_MUL = 4'hE;
  localparam logic [FIELD_W-1:0] OP_MOD = 4'hF;

  typedef struct packed {
    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] src1;
    logic [FIELD_W-1:0] src2;
    logic [FIELD_W-1:0] dst;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/prog_buf.sv
// Program buffer: DEPTH x INSTR_W register file, one sync write port,
// one async read port with write-first bypass.
module prog_buf
  import seq_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata_c
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-cycle write to the read address is forwarded so start sees the new word.
  assign rdata_c = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: issues buffered instructions to the datapath over valid/ready.
// Optional build macro SEQ_LOOP_EN adds a loop input that restarts the program at entry 0.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [AW:0]        prog_len,
  input  logic               start,
  input  logic               abort,
`ifdef SEQ_LOOP_EN
  input  logic               loop,
`endif
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state, state_nxt;
  logic [AW:0]        len, len_nxt;
  logic [AW-1:0]      pc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic               valid_nxt, busy_nxt, done_nxt, err_nxt;
  logic               accept_c, last_c, len_ok_c, loop_c, buf_we_c;
  logic [AW-1:0]      rd_addr_c;
  logic [INSTR_W-1:0] rd_data_c;

`ifdef SEQ_LOOP_EN
  assign loop_c = loop;
`else
  assign loop_c = 1'b0;
`endif

  assign accept_c = instr_valid & instr_ready;
  assign last_c   = ({1'b0, pc} == (len - (AW+1)'(1)));
  assign len_ok_c = (prog_len != '0) && (prog_len <= (AW+1)'(DEPTH));
  assign buf_we_c = rst_n & load_en & (state == IDLE);

  // Read the successor while issuing; otherwise entry 0 for start or loop wrap.
  assign rd_addr_c = ((state == ISSUE) && !last_c) ? AW'(pc + AW'(1)) : '0;

  prog_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .we      (buf_we_c),
    .waddr   (load_addr),
    .wdata   (load_data),
    .raddr   (rd_addr_c),
    .rdata_c (rd_data_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      len         <= '0;
      pc          <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      len         <= len_nxt;
      pc          <= pc_nxt;
      instr_out   <= instr_nxt;
      instr_valid <= valid_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    pc_nxt    = pc;
    instr_nxt = instr_out;
    valid_nxt = instr_valid;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (len_ok_c) begin
            len_nxt   = prog_len;
            pc_nxt    = '0;
            instr_nxt = rd_data_c;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b1;
            state_nxt = ISSUE;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        err_nxt = load_en;
        if (accept_c) begin
          if (!last_c || loop_c) begin
            pc_nxt    = rd_addr_c;
            instr_nxt = rd_data_c;
          end else begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            pc_nxt    = '0;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        err_nxt   = load_en;
        pc_nxt    = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort outranks everything except reset, and only acts while running.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
      busy_nxt  = 1'b0;
      pc_nxt    = '0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer against a program-order reference model.
module tb_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, load_en, start, abort, instr_ready;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic [AW:0]   prog_len;
  logic [15:0]   instr_out;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy, done, err;
`ifdef SEQ_LOOP_EN
  logic          loop;
`endif

  logic [15:0] model_mem [DEPTH];
  int errors = 0;
  int checks = 0;

  instr_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_len    (prog_len),
    .start       (start),
    .abort       (abort),
`ifdef SEQ_LOOP_EN
    .loop        (loop),
`endif
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [15:0] w);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = w;
    tick();
    load_en   = 1'b0;
    model_mem[a] = w;
  endtask

  // Runs one program of len instructions; mode 0 ready=1, 1 random ready, 2 pattern 1,0,0,1,1.
  task automatic test_run(input int len, input int mode, input string name);
    int idx = 0;
    int cyc = 0;
    logic r;
    int pat [5];
    pat = '{1, 0, 0, 1, 1};
    prog_len = (AW+1)'(len);
    start = 1'b1;
    tick();
    start   = 1'b0;
    load_en = 1'b0;
    while (idx < len && cyc < 400) begin
      checks++;
      if (instr_valid !== 1'b1) begin errors++; $display("FAIL %s valid: got %b expected 1 (idx %0d)", name, instr_valid, idx); end
      checks++;
      if (instr_out !== model_mem[idx]) begin errors++; $display("FAIL %s instr_out: got %h expected %h (idx %0d)", name, instr_out, model_mem[idx], idx); end
      checks++;
      if (pc !== AW'(idx)) begin errors++; $display("FAIL %s pc: got %0d expected %0d", name, pc, idx); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b expected 1", name, busy); end
      if (mode == 0) r = 1'b1;
      else if (mode == 2) r = (cyc < 5) ? (pat[cyc] != 0) : 1'b1;
      else r = ($urandom_range(0, 2) != 0);
      instr_ready = r;
      if (mode == 1) start = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL %s err_in_issue: got %b expected 0", name, err); end
      if (r) idx++;
      cyc++;
    end
    instr_ready = 1'b0;
    start = 1'b0;
    if (cyc >= 400) begin errors++; $display("FAIL %s timeout: got %0d accepts expected %0d", name, idx, len); end
    if (mode == 2) begin
      checks++;
      if (cyc !== 5) begin errors++; $display("FAIL %s ready_cycles: got %0d expected 5", name, cyc); end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done_pulse: got %b expected 1", name, done); end
    checks++;
    if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s done_state: got valid=%b busy=%b expected 0 0", name, instr_valid, busy); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b expected 0", name, done); end
    checks++;
    if (pc !== '0) begin errors++; $display("FAIL %s pc_idle: got %0d expected 0", name, pc); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (pc !== '0 || instr_out !== 16'h0000) begin errors++; $display("FAIL reset_pc_instr: got pc=%0d instr=%h expected 0 0000", pc, instr_out); end
    checks++;
    if ({instr_valid, busy, done, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {instr_valid, busy, done, err}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    load_word(0, 16'h0050);
    load_word(1, 16'h0071);
    load_word(2, 16'hB012);
    test_run(3, 0, "basic");
  endtask

  task automatic test_stall();
    test_run(3, 2, "stall");
  endtask

  task automatic test_bad_len();
    int lens [2];
    lens = '{0, DEPTH + 1};
    foreach (lens[i]) begin
      prog_len = (AW+1)'(lens[i]);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL bad_len_err: got %b expected 1 (len %0d)", err, lens[i]); end
      checks++;
      if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bad_len_idle: got valid=%b busy=%b expected 0 0", instr_valid, busy); end
      tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL bad_len_err_width: got %b expected 0", err); end
    end
  endtask

  task automatic test_load_during_issue();
    int cyc = 0;
    prog_len = (AW+1)'(3);
    start = 1'b1;
    instr_ready = 1'b0;
    tick();
    start     = 1'b0;
    load_en   = 1'b1;
    load_addr = AW'(1);
    load_data = 16'hFFFF;
    tick();
    load_en = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL load_issue_err: got %b expected 1", err); end
    checks++;
    if (instr_valid !== 1'b1 || pc !== '0) begin errors++; $display("FAIL load_issue_hold: got valid=%b pc=%0d expected 1 0", instr_valid, pc); end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL load_issue_err_width: got %b expected 0", err); end
    while (done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    instr_ready = 1'b0;
    if (cyc >= 20) begin errors++; $display("FAIL load_issue_timeout: got no done expected done"); end
    tick();
    test_run(3, 0, "after_load_issue");
  endtask

  task automatic test_abort();
    for (int i = 0; i < 4; i++) load_word(i, 16'($urandom));
    prog_len = (AW+1)'(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (pc !== AW'(1)) begin errors++; $display("FAIL abort_pre_pc: got %0d expected 1", pc); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || busy !== 1'b0 || pc !== '0) begin errors++; $display("FAIL abort_state: got valid=%b busy=%b pc=%0d expected 0 0 0", instr_valid, busy, pc); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done_late: got %b expected 0", done); end
    test_run(4, 1, "after_abort");
  endtask

  task automatic test_bypass();
    logic [15:0] w;
    w = 16'($urandom);
    load_en   = 1'b1;
    load_addr = '0;
    load_data = w;
    model_mem[0] = w;
    test_run(2, 0, "bypass");
  endtask

  task automatic test_reset_mid();
    prog_len = (AW+1)'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    instr_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || busy !== 1'b0 || pc !== '0) begin errors++; $display("FAIL reset_mid: got valid=%b busy=%b pc=%0d expected 0 0 0", instr_valid, busy, pc); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom));
    for (int round = 0; round < 6; round++) begin
      for (int k = 0; k < 3; k++) load_word($urandom_range(0, DEPTH - 1), 16'($urandom));
      test_run((round == 0) ? DEPTH : $urandom_range(1, DEPTH), 1, "random");
    end
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    load_word(0, 16'h3123);
    load_word(1, 16'h4456);
    loop = 1'b1;
    prog_len = (AW+1)'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (pc !== AW'(k % 2) || instr_out !== model_mem[k % 2]) begin errors++; $display("FAIL loop_seq: got pc=%0d instr=%h expected %0d %h", pc, instr_out, k % 2, model_mem[k % 2]); end
      checks++;
      if (done !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL loop_running: got done=%b valid=%b expected 0 1", done, instr_valid); end
      if (k == 4) loop = 1'b0;
      tick();
    end
    instr_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL loop_stop: got done=%b valid=%b expected 1 0", done, instr_valid); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL loop_done_once: got %b expected 0", done); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0; instr_ready = 1'b0;
`ifdef SEQ_LOOP_EN
    loop = 1'b0;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_bad_len();
    test_load_during_issue();
    test_abort();
    test_bypass();
    test_reset_mid();
    test_random();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer for the 8-bit ALU/memory datapath (16-bit instruction: opcode[15:12], src1[11:8], src2[7:4], dst[3:0]).
- Holds a small program buffer loaded by the host. On start, it issues the stored instructions in order to the datapath over a valid/ready handshake, then reports completion.
- Sits between the host/testbench and the datapath. instr_valid acts as the datapath's execute enable.

Parameters:
- DEPTH, 16, number of program buffer entries (power of two, at least 2).
- AW, $clog2(DEPTH), buffer address width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- load_en  input  1  write load_data into buffer[load_addr]; honoured in IDLE only.
- load_addr  input  AW  buffer write address.
- load_data  input  16  instruction word to store.
- prog_len  input  AW+1  number of instructions to run; sampled on start.
- start  input  1  begin execution from entry 0.
- abort  input  1  cancel execution.
- instr_out  output  16  instruction presented to the datapath.
- instr_valid  output  1  instr_out is valid; datapath executes on a cycle where valid and ready are both high.
- instr_ready  input  1  datapath accepts instr_out.
- pc  output  AW  index of the instruction currently presented.
- busy  output  1  high in ISSUE state.
- done  output  1  one-cycle pulse after the last instruction is accepted.
- err  output  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; pc=0; instr_out=16'h0000; instr_valid=0; busy=0; done=0; err=0.
  - Buffer contents are not reset.
- State machine: IDLE -> ISSUE -> DONE -> IDLE.
- IDLE:
  - load_en writes the buffer at the clock edge.
  - start with 1 <= prog_len <= DEPTH:
    - latch len=prog_len; pc=0; instr_out=buffer[0]; instr_valid=1; busy=1; go to ISSUE.
    - Latency: instr_valid is high the cycle after start.
  - start with prog_len==0 or prog_len>DEPTH: err=1 for one cycle; stay IDLE.
  - load_en and start in the same cycle: the write completes first, and the read of entry 0 returns the new word (write-first bypass).
- ISSUE:
  - instr_out and pc hold stable while instr_valid=1 and instr_ready=0.
  - On valid&ready with pc<len-1: pc=pc+1; instr_out=buffer[pc+1]; instr_valid stays 1. Throughput is one instruction per cycle with ready held high.
  - On valid&ready with pc==len-1: instr_valid=0; busy=0; go to DONE.
- DONE: done=1 for exactly one cycle; pc=0; go to IDLE.
- Priority: rst_n > abort > start/load.
- abort in ISSUE or DONE:
  - next cycle state=IDLE, instr_valid=0, busy=0, pc=0, done=0, err=0.
  - An instruction handshaked in the abort cycle counts as executed.
  - abort in IDLE has no effect.
- load_en while not IDLE: write dropped; err=1 for one cycle.
- start while not IDLE: ignored; no err.
- prog_len==DEPTH: pc reaches DEPTH-1 with no wrap past it.
- A reset mid-program returns to IDLE immediately. The instruction presented at that edge is not executed (valid forced to 0).

Optional Feature:
- Macro SEQ_LOOP_EN.
- Defined:
  - Adds input port loop (1 bit).
  - When the last instruction is accepted and loop=1, pc wraps to 0, instr_out=buffer[0], instr_valid stays 1, and no done pulse is issued.
  - Running continues until the last instruction is accepted with loop=0, or until abort.
- Undefined: no loop port; execution always stops after len instructions.

Decomposition:
- Package seq_pkg:
  - INSTR_W=16.
  - opcode field localparams (OP_LDI=4'h0 ... OP_MOD=4'hF).
  - field bit ranges.
  - state typedef enum {IDLE, ISSUE, DONE}.
- Sub-module prog_buf:
  - DEPTH x 16 register file.
  - one synchronous write port, one asynchronous read port, write-first bypass.
  - Instantiated once.

Test Plan:
- Load entries 0..2 = 16'h0050, 16'h0071, 16'hB012; start, prog_len=3, ready held 1 -> valid high for 3 consecutive cycles with pc 0,1,2 and those words in order; done pulses the cycle after the third accept; busy low in DONE.
- Same program, ready toggles 1,0,0,1,1 -> instr_out/pc held during ready=0; exactly 3 accepts; done after the 5th ready cycle.
- start with prog_len=0, and again with prog_len=DEPTH+1 -> err one-cycle pulse each time; valid stays 0; state stays IDLE.
- load_en during ISSUE (addr 1, data 16'hFFFF) -> err pulse; entry 1 unchanged when re-read on the next run.
- abort asserted while pc=1 of a 4-instruction program -> valid 0 next cycle, pc=0, no done pulse; a following start runs from entry 0.
- With SEQ_LOOP_EN defined: loop=1, prog_len=2 -> pc sequence 0,1,0,1...; drop loop during the 3rd pass -> stops after pc=1 is accepted; done pulses once.
